// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential AXI instruction prefetcher feeding decode through a small FIFO.
module ifu_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    output logic [2:0]      arsize,
    input  logic            rvalid,
    output logic            rready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HALT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  araddr_q, araddr_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             drop_q, drop_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  inst_q  [DEPTH];
    logic [XLEN-1:0]  inst_d  [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  pc_d    [DEPTH];
    logic             fault_q [DEPTH];
    logic             fault_d [DEPTH];

    logic have_room_c;
    logic ar_accept_c;
    logic r_beat_c;
    logic push_c;
    logic pop_c;

    // Handshake qualifiers; a push is suppressed by a pending drop or a same-cycle redirect
    assign have_room_c = (count_q < CNT_W'(DEPTH));
    assign ar_accept_c = (state_q == S_ADDR) && arready;
    assign r_beat_c    = (state_q == S_DATA) && rvalid;
    assign push_c      = r_beat_c && !drop_q && !redirect_valid;
    assign pop_c       = (count_q != '0) && out_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one outstanding read; a faulting beat parks the fetcher in HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!redirect_valid && have_room_c) state_d = S_ADDR;
            S_ADDR: if (arready) state_d = S_DATA;
            S_DATA: begin
                if (rvalid) begin
                    if (drop_q || redirect_valid || !(|rresp)) state_d = S_IDLE;
                    else                                        state_d = S_HALT;
                end
            end
            S_HALT: if (redirect_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: AR valid while addressing, R ready while waiting for the beat
    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        case (state_q)
            S_ADDR:  arvalid = 1'b1;
            S_DATA:  rready  = 1'b1;
            default: ;
        endcase
    end

    // Fetch address, request pc and drop tracking; redirect overrides the sequential pc
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        araddr_d   = araddr_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        if ((state_q == S_IDLE) && (state_d == S_ADDR)) araddr_d = fetch_pc_q;
        if (ar_accept_c) begin
            req_pc_d = araddr_q;
            // after a redirect fetch_pc already holds the target and must not advance
            if (!drop_q) fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (r_beat_c) drop_d = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            if ((state_q == S_ADDR) || ((state_q == S_DATA) && !rvalid)) drop_d = 1'b1;
        end
    end

    // Prefetch FIFO bookkeeping; redirect flushes after honouring the same-cycle pop
    always_comb begin
        inst_d   = inst_q;
        pc_d     = pc_q;
        fault_d  = fault_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            inst_d[wr_ptr_q]  = rdata;
            pc_d[wr_ptr_q]    = req_pc_q;
            fault_d[wr_ptr_q] = |rresp;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Datapath and FIFO storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            araddr_q   <= '0;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]  <= '0;
                pc_q[i]    <= '0;
                fault_q[i] <= 1'b0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_inst  = inst_q[rd_ptr_q];
    assign out_pc    = pc_q[rd_ptr_q];
    assign out_fault = fault_q[rd_ptr_q];
    assign araddr    = araddr_q;
    assign arsize    = 3'b010;

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scenarios plus randomized traffic against a queue-based fetch model.
module tb_ifu_prefetch;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NO_ERR   = 32'hFFFF_FFF0;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arsize;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_fault(out_fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    int          checks;
    int          errors;
    ent_t        exp_q[$];
    logic [31:0] ar_log[$];
    logic [31:0] exp_fetch;
    bit          stale, halted, r_pending, r_err, rand_mode;
    logic [1:0]  r_resp_val;
    logic [31:0] r_addr, err_pc, prev_araddr, old_addr;
    bit          prev_arvalid, prev_arready;
    int          ar_cnt, r_cnt, ar_lat, r_lat, cfg_ar_lat, cfg_r_lat;
    int          ar_hs, pops, fault_pops, hs_before;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ar_log.delete();
        exp_fetch    = RESET_PC;
        stale        = 1'b0;
        halted       = 1'b0;
        r_pending    = 1'b0;
        r_err        = 1'b0;
        r_resp_val   = 2'b00;
        r_addr       = '0;
        prev_arvalid = 1'b0;
        prev_arready = 1'b0;
        prev_araddr  = '0;
        ar_cnt = 0; r_cnt = 0; ar_lat = 0; r_lat = 0;
        ar_hs = 0; pops = 0; fault_pops = 0;
    endtask

    // Hold reset across two edges, release mid-cycle, return 1 unit after the first live edge
    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        arready        = 1'b0;
        rvalid         = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive memory/redirect inputs, check outputs against the model, advance the model
    task automatic tick(input bit redir, input logic [31:0] rpc);
        bit av, ar, rv, rr, rp, ov;
        if (arvalid === 1'b1 && !prev_arvalid) ar_lat = rand_mode ? int'($urandom_range(0, 3)) : cfg_ar_lat;
        arready        = (arvalid === 1'b1) && (ar_cnt >= ar_lat);
        rvalid         = r_pending && (r_cnt >= r_lat);
        rdata          = mem_word(r_addr);
        rresp          = rvalid ? r_resp_val : 2'b00;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0 && out_valid === 1'b1) begin
            check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
            check("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
            check("out_fault", 64'(out_fault), 64'(exp_q[0].fault));
        end
        if (arvalid === 1'b1 && !prev_arvalid) check("ar_start_addr", 64'(araddr), 64'(exp_fetch));
        if (prev_arvalid && !prev_arready) begin
            check("ar_hold_valid", 64'(arvalid), 64'd1);
            check("ar_hold_addr", 64'(araddr), 64'(prev_araddr));
        end
        if (halted) check("halt_no_ar", 64'(arvalid), 64'd0);
        if (exp_q.size() >= DEPTH) check("full_no_ar", 64'(arvalid), 64'd0);
        check("rready", 64'(rready), 64'(r_pending));

        av = (arvalid === 1'b1);
        ar = arready;
        rv = rvalid;
        rr = (rready === 1'b1);
        rp = r_pending;
        ov = (out_valid === 1'b1);

        if (ov && out_ready) begin
            pops++;
            if (out_fault === 1'b1) fault_pops++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (rp && !(rv && rr)) r_cnt++;
        if (rv && rr) begin
            if (!stale && !redir) begin
                exp_q.push_back('{pc: r_addr, inst: mem_word(r_addr), fault: r_err});
                if (r_err) halted = 1'b1;
            end
            stale     = 1'b0;
            r_pending = 1'b0;
        end
        if (av && ar) begin
            ar_hs++;
            ar_log.push_back(araddr);
            r_pending  = 1'b1;
            r_addr     = araddr;
            r_cnt      = 0;
            r_lat      = rand_mode ? int'($urandom_range(0, 3)) : cfg_r_lat;
            r_err      = (araddr == err_pc) || (rand_mode && ($urandom_range(0, 24) == 0));
            r_resp_val = !r_err ? 2'b00 : (rand_mode ? 2'($urandom_range(1, 3)) : 2'b10);
            if (!stale && !redir) exp_fetch = exp_fetch + 32'd4;
            ar_cnt = 0;
        end else if (av) begin
            ar_cnt++;
        end else begin
            ar_cnt = 0;
        end
        if (redir) begin
            exp_q.delete();
            if (av || (rp && !rv)) stale = 1'b1;
            halted    = 1'b0;
            exp_fetch = rpc & ~32'd3;
        end
        prev_arvalid = av;
        prev_arready = ar;
        prev_araddr  = araddr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        cfg_ar_lat = 0; cfg_r_lat = 0; rand_mode = 1'b0; err_pc = NO_ERR;
        rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        model_reset();

        // reset values, then first request one cycle after release
        #12;
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_fault", 64'(out_fault), 64'd0);
        check("arsize", 64'(arsize), 64'd2);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_arvalid", 64'(arvalid), 64'd1);
        check("first_araddr", 64'(araddr), 64'(RESET_PC));

        // sequential fetch with single-cycle memory
        out_ready = 1'b1;
        for (int i = 0; i < 60 && pops < 3; i++) tick(1'b0, '0);
        check("t1_ar_count", 64'(ar_log.size() >= 3), 64'd1);
        for (int k = 0; k < 3; k++)
            check("t1_araddr", 64'((k < ar_log.size()) ? ar_log[k] : 32'hx), 64'(RESET_PC + 32'(4 * k)));

        // stalled decode fills the FIFO, then drains and fetch resumes
        out_ready = 1'b0;
        do_reset();
        repeat (40) tick(1'b0, '0);
        check("t2_ar_hs", 64'(ar_hs), 64'd4);
        check("t2_arvalid_idle", 64'(arvalid), 64'd0);
        check("t2_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) tick(1'b0, '0);
        check("t2_resume_addr", 64'(araddr), 64'h8000_0010);
        repeat (10) tick(1'b0, '0);
        check("t2_pops", 64'(pops >= 4), 64'd1);

        // redirect while waiting for the R beat
        out_ready = 1'b0;
        cfg_r_lat = 3;
        do_reset();
        for (int i = 0; i < 100 && !(ar_hs >= 3 && rready === 1'b1); i++) tick(1'b0, '0);
        tick(1'b1, 32'h8000_0103);
        check("t3_flushed", 64'(out_valid), 64'd0);
        cfg_r_lat = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && arvalid !== 1'b1; i++) tick(1'b0, '0);
        check("t3_redirect_addr", 64'(araddr), 64'h8000_0100);

        // redirect while AR is stalled by the slave
        cfg_ar_lat = 3;
        do_reset();
        old_addr = araddr;
        tick(1'b1, 32'h8000_0200);
        cfg_ar_lat = 0;
        hs_before = ar_hs;
        for (int i = 0; i < 20 && ar_hs == hs_before; i++) tick(1'b0, '0);
        check("t4_old_addr", 64'((ar_log.size() != 0) ? ar_log[ar_log.size() - 1] : 32'hx), 64'(old_addr));
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) tick(1'b0, '0);
        check("t4_redirect_addr", 64'(araddr), 64'h8000_0200);
        repeat (10) tick(1'b0, '0);

        // bus error halts fetching until a redirect
        out_ready = 1'b0;
        err_pc = 32'h8000_0008;
        do_reset();
        repeat (30) tick(1'b0, '0);
        check("t5_ar_hs", 64'(ar_hs), 64'd3);
        check("t5_halted", 64'(arvalid), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (6) tick(1'b0, '0);
        check("t5_fault_pops", 64'(fault_pops), 64'd1);
        err_pc = NO_ERR;
        tick(1'b1, 32'h8000_0000);
        for (int i = 0; i < 20 && arvalid !== 1'b1; i++) tick(1'b0, '0);
        check("t5_resume_addr", 64'(araddr), 64'h8000_0000);

        // asynchronous reset in the middle of a data phase
        out_ready = 1'b0;
        cfg_r_lat = 3;
        do_reset();
        for (int i = 0; i < 60 && !(ar_hs >= 2 && rready === 1'b1); i++) tick(1'b0, '0);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_arvalid", 64'(arvalid), 64'd0);
        check("t6_rready", 64'(rready), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_inst", 64'(out_inst), 64'd0);
        check("t6_out_pc", 64'(out_pc), 64'd0);
        check("t6_out_fault", 64'(out_fault), 64'd0);
        cfg_r_lat = 0;
        do_reset();
        check("t6_restart_valid", 64'(arvalid), 64'd1);
        check("t6_restart_addr", 64'(araddr), 64'(RESET_PC));

        // randomized latencies, backpressure, redirects and bus errors
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            tick($urandom_range(0, 19) == 0, 32'h8000_0000 + 32'($urandom_range(0, 1023)));
        end
        check("rand_progress", 64'(pops > 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
Parametrised instruction fetch unit with a DEPTH-entry prefetch FIFO. It issues sequential AXI read requests ahead of decode, one outstanding transaction at a time. It buffers {pc, inst, fault} entries and hands them to the IDU through a valid/ready port. Redirects from WBU (branch, jump, trap) flush the buffer and discard any in-flight response, and a bus error halts fetching until the next redirect.

Parameters:
XLEN, 32, instruction/address width
DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
RESET_PC, 32'h8000_0000, fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored (forced 0)
out_valid  output  1  FIFO head valid to IDU
out_ready  input  1  IDU accepts head
out_inst  output  XLEN  head instruction
out_pc  output  XLEN  head pc
out_fault  output  1  head fetched with rresp != 0
araddr  output  XLEN  AXI read address
arvalid  output  1  AXI AR valid
arready  input  1  AXI AR ready
arsize  output  3  constant 3'b010
rvalid  input  1  AXI R valid
rready  output  1  AXI R ready
rdata  input  XLEN  AXI read data
rresp  input  2  AXI read response

Behaviour:
- Reset (rst low, async): fetch_pc=RESET_PC; state=IDLE; FIFO count, rd_ptr, wr_ptr=0; drop=0. Outputs: arvalid=0, rready=0, out_valid=0, out_inst/out_pc=0, out_fault=0.
- State IDLE: if no redirect this cycle and count < DEPTH, go to ADDR. A slot is reserved for the outstanding response, so a push can never overflow.
- State ADDR: arvalid=1, araddr=fetch_pc, both held stable until arready. On arvalid&arready: latch req_pc=fetch_pc; fetch_pc+=4 (wraps mod 2^XLEN); go to DATA.
- State DATA: rready=1. On rvalid:
  - drop=1: discard the beat, clear drop, go to IDLE.
  - Otherwise, push {req_pc, rdata, rresp!=0}.
  - Then, if rresp!=0, go to HALT; else go to IDLE.
- State HALT: no requests are issued. Only a redirect exits HALT.
- Redirect (redirect_valid=1), highest priority, effective at the next edge:
  - FIFO count and pointers are cleared; out_valid=0 next cycle.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - In IDLE or HALT: go to IDLE.
  - In ADDR: arvalid stays high until arready (AXI rule, never retracted). The transaction completes with araddr = the old fetch_pc, and drop is set. fetch_pc is still loaded from redirect_pc and is not incremented by that accept.
  - In DATA: set drop, unless rvalid is high in the same cycle; in that case the beat is discarded directly and the state goes to IDLE.
  - A pop handshake in the redirect cycle is honoured; the rest of the FIFO is flushed. A push in the redirect cycle is suppressed.
- FIFO:
  - out_valid = (count != 0); out_inst, out_pc, out_fault come from the head entry.
  - Pop on out_valid&out_ready. out_ready while empty has no effect.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Latency:
  - First arvalid is asserted 1 cycle after reset release (IDLE→ADDR).
  - The R beat accepted at edge N gives out_valid=1 after edge N when the FIFO was empty.
  - Back-to-back throughput is one instruction per 3 cycles plus memory latency.
- Stalls: with out_ready=0, fetch continues until count = DEPTH, then stays in IDLE.

Test Plan:
- Reset release, memory with 1-cycle arready and 1-cycle rvalid, out_ready=1 → araddr sequence 0x80000000, 0x80000004, 0x80000008. out_pc matches araddr and out_inst matches rdata, in order.
- out_ready=0, DEPTH=4 → exactly 4 AR handshakes, then arvalid stays 0. Raising out_ready pops 4 entries and fetch resumes at 0x80000010.
- redirect_valid with redirect_pc=0x80000103 while in DATA with rvalid=0 → the returned beat is not pushed. Next araddr=0x80000100, FIFO is empty the cycle after the redirect.
- redirect in ADDR with arready held low for 3 cycles → arvalid stays high and araddr stays at the old address until arready. That response is dropped; the next araddr is the redirect target.
- rresp=2'b10 on a beat for pc 0x80000008 → entry is presented with out_fault=1 and no further arvalid. A redirect to 0x80000000 resumes fetching.
- Assert rst low mid-DATA → all outputs go to their reset values immediately (async). After release, fetch restarts at RESET_PC.
